dht_reader: RTL and testbench

// Single-wire reader for the DHT22/AM2302 humidity/temperature sensor; produces the
// 40-bit HT_data word consumed by the display pixel generator. Periodically issues
// a start pulse, decodes the sensor's 40-bit pulse-width frame, verifies the checksum,
// and updates the held output word only on a good frame. Runs in the 25 MHz VGA clock domain.

---
 rtl/dht_reader.sv | 195 +++++++++++++++++++
 tb/tb_dht_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dht_reader.sv
`timescale 1ns/1ps
// dht_reader: single-wire reader for the DHT22/AM2302 sensor.
// Periodically pulls the line low to request a frame, decodes the 40-bit
// pulse-width reply MSB first and publishes it on HT_data only when the
// checksum byte matches the byte sum of the four data bytes.
//
// state      | meaning
// S_IDLE     | line released; count sample period while en=1
// S_START    | host drives line low for START_LOW_US
// S_WAIT_ACK | line released; wait sensor falling edge
// S_ACK_LOW  | sensor ack low phase; wait rising edge
// S_ACK_HIGH | sensor ack high phase; wait falling edge
// S_BIT_LOW  | bit preamble low; wait rising edge
// S_BIT_HIGH | bit high phase; width decides bit value on falling edge
// S_CHECK    | one cycle: checksum compare, publish or flag error
module dht_reader #(
  parameter int CLK_FREQ_MHZ     = 25,
  parameter int SAMPLE_PERIOD_MS = 2000,
  parameter int START_LOW_US     = 1100,
  parameter int BIT_THRESH_US    = 48,
  parameter int TIMEOUT_US       = 200
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        en,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic [39:0] HT_data,
  output logic        data_valid,
  output logic        crc_err,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_ACK, S_ACK_LOW, S_ACK_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
  } state_t;

  localparam int PERIOD_US = SAMPLE_PERIOD_MS * 1000;
  localparam int MAX_ST    = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int TMR_MAX   = (PERIOD_US > MAX_ST) ? PERIOD_US : MAX_ST;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int DIV_W     = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_FREQ_MHZ - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST  = TMR_W'(PERIOD_US - 1);
  localparam logic [TMR_W-1:0] START_LAST   = TMR_W'(START_LOW_US - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_US - 1);
  localparam logic [TMR_W-1:0] THRESH       = TMR_W'(BIT_THRESH_US);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic              us_tick;
  logic [2:0]        sync_q;
  logic              rise, fall, edge_hit;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [39:0]       shift_q, shift_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [39:0]       ht_q, ht_d;
  logic              dv_q, dv_d, crc_q, crc_d, to_q, to_d;
  logic [7:0]        sum;

  assign us_tick = (div_q == DIV_LAST);
  // [0],[1] synchronize the pad; [2] is the previous synced sample for edge detect
  assign rise     = ~sync_q[2] &  sync_q[1];
  assign fall     =  sync_q[2] & ~sync_q[1];
  assign edge_hit = ((state_q == S_ACK_LOW) || (state_q == S_BIT_LOW)) ? rise : fall;
  assign sum      = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  // Microsecond tick divider and input synchronizer (idle line reads high)
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sync_q <= 3'b111;
    end else begin
      div_q  <= us_tick ? '0 : div_q + DIV_W'(1);
      sync_q <= {sync_q[1:0], dht_in};
    end
  end

  // State, timer, shift register and registered output pulses
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ht_q      <= '0;
      dv_q      <= 1'b0;
      crc_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ht_q      <= ht_d;
      dv_q      <= dv_d;
      crc_q     <= crc_d;
      to_q      <= to_d;
    end
  end

  // Next-state logic; one shared us timer restarts on every state change
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ht_d      = ht_q;
    dv_d      = 1'b0;
    crc_d     = 1'b0;
    to_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!en) begin
          tmr_d = '0;
        end else if (us_tick) begin
          if (tmr_q == PERIOD_LAST) begin
            state_d = S_START;
            tmr_d   = '0;
            shift_d = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
      S_START: begin
        if (us_tick) begin
          if (!en) begin
            state_d = S_IDLE;
            tmr_d   = '0;
          end else if (tmr_q == START_LAST) begin
            state_d = S_WAIT_ACK;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
      S_WAIT_ACK, S_ACK_LOW, S_ACK_HIGH, S_BIT_LOW, S_BIT_HIGH: begin
        if (edge_hit) begin
          tmr_d = '0;
          case (state_q)
            S_WAIT_ACK: state_d = S_ACK_LOW;
            S_ACK_LOW:  state_d = S_ACK_HIGH;
            S_ACK_HIGH: begin
              state_d   = S_BIT_LOW;
              bit_cnt_d = '0;
            end
            S_BIT_LOW:  state_d = S_BIT_HIGH;
            default: begin
              shift_d   = {shift_q[38:0], (tmr_q > THRESH)};
              bit_cnt_d = bit_cnt_q + 6'd1;
              state_d   = (bit_cnt_q == 6'd39) ? S_CHECK : S_BIT_LOW;
            end
          endcase
        end else if (us_tick) begin
          if (!en) begin
            state_d = S_IDLE;
            tmr_d   = '0;
          end else if (tmr_q == TIMEOUT_LAST) begin
            to_d    = 1'b1;
            state_d = S_IDLE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
      S_CHECK: begin
        if (sum == shift_q[7:0]) begin
          ht_d = shift_q;
          dv_d = 1'b1;
        end else begin
          crc_d = 1'b1;
        end
        state_d = S_IDLE;
        tmr_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  assign dht_oe      = (state_q == S_START);
  assign busy        = (state_q != S_IDLE);
  assign HT_data     = ht_q;
  assign data_valid  = dv_q;
  assign crc_err     = crc_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_dht_reader.sv
`timescale 1ns/1ps
// tb_dht_reader: sensor bus-functional model plus frame-level reference model.
module tb_dht_reader;

  localparam int CLK_MHZ = 1;

  logic        clk = 1'b0;
  logic        rst_n, en, sensor_low;
  logic        dht_in, dht_oe, data_valid, crc_err, timeout_err, busy;
  logic [39:0] HT_data;

  always #5 clk = ~clk;

  // open-drain bus with external pull-up
  assign dht_in = ~(dht_oe | sensor_low);

  dht_reader #(
    .CLK_FREQ_MHZ(CLK_MHZ), .SAMPLE_PERIOD_MS(1), .START_LOW_US(1100),
    .BIT_THRESH_US(48), .TIMEOUT_US(200)
  ) dut (
    .clk_25MHz(clk), .rst_n(rst_n), .en(en), .dht_in(dht_in), .dht_oe(dht_oe),
    .HT_data(HT_data), .data_valid(data_valid), .crc_err(crc_err),
    .timeout_err(timeout_err), .busy(busy)
  );

  int n_checks = 0, n_fail = 0;
  int n_valid = 0, n_crc = 0, n_to = 0, oe_rises = 0, oe_cnt = 0, last_oe_w = 0;
  int n_contend = 0, n_long = 0;
  logic oe_prev = 1'b0, dv_prev = 1'b0, crc_prev = 1'b0, to_prev = 1'b0;

  // bus monitor: pulse counts, start-pulse width, contention, pulse length
  always @(negedge clk) begin
    if (data_valid) n_valid++;
    if (crc_err) n_crc++;
    if (timeout_err) n_to++;
    if ((data_valid && dv_prev) || (crc_err && crc_prev) || (timeout_err && to_prev)) n_long++;
    if (dht_oe && sensor_low) n_contend++;
    if (dht_oe && !oe_prev) begin oe_rises++; oe_cnt = 0; end
    if (dht_oe) oe_cnt++;
    if (!dht_oe && oe_prev) last_oe_w = oe_cnt;
    oe_prev = dht_oe; dv_prev = data_valid; crc_prev = crc_err; to_prev = timeout_err;
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic hold(input int us);
    repeat (us * CLK_MHZ) @(negedge clk);
  endtask

  task automatic wait_oe(input logic lvl, input int max, output int cyc);
    cyc = 0;
    while (dht_oe !== lvl && cyc <= max) begin @(negedge clk); cyc++; end
  endtask

  task automatic wait_idle(input int max, output int cyc);
    cyc = 0;
    while (busy !== 1'b0 && cyc <= max) begin @(negedge clk); cyc++; end
  endtask

  task automatic wait_to(input int t0, input int max, output int cyc);
    cyc = 0;
    while (n_to == t0 && cyc <= max) begin @(negedge clk); cyc++; end
  endtask

  // sensor: answer one start request with nbits bits of f (nbits<0: stay silent)
  task automatic sensor_frame(input logic [39:0] f, input int nbits, input bit rnd);
    int c;
    wait_oe(1'b1, 3000, c); chk_rng("start_seen", c, 0, 3000);
    wait_oe(1'b0, 1500, c); chk_rng("start_release", c, 0, 1500);
    if (nbits >= 0) begin
      hold(rnd ? $urandom_range(20, 40) : 30);
      sensor_low = 1'b1; hold(80);
      sensor_low = 1'b0; hold(80);
      for (int i = 0; i < nbits; i++) begin
        sensor_low = 1'b1; hold(rnd ? $urandom_range(40, 60) : 50);
        sensor_low = 1'b0;
        if (f[39-i]) hold(rnd ? $urandom_range(58, 80) : 70);
        else         hold(rnd ? $urandom_range(15, 38) : 26);
      end
      if (nbits == 40) begin
        sensor_low = 1'b1; hold(50);
        sensor_low = 1'b0;
      end
    end
  endtask

  // frame-level reference: publish only if byte sum of data bytes mod 256 equals checksum
  function automatic void ref_frame(input logic [39:0] f, inout logic [39:0] ht,
                                    output int v, output int c);
    int s;
    logic [39:0] t;
    s = 0;
    for (int k = 1; k < 5; k++) begin
      t = f >> (8 * k);
      s += int'(t[7:0]);
    end
    if ((s % 256) == int'(f[7:0])) begin ht = f; v = 1; c = 0; end
    else begin v = 0; c = 1; end
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_oe"}, {39'd0, dht_oe}, 40'd0);
    chk({tag, "_ht"}, HT_data, 40'd0);
    chk({tag, "_dv"}, {39'd0, data_valid}, 40'd0);
    chk({tag, "_crc"}, {39'd0, crc_err}, 40'd0);
    chk({tag, "_to"}, {39'd0, timeout_err}, 40'd0);
    chk({tag, "_busy"}, {39'd0, busy}, 40'd0);
  endtask

  typedef struct {
    string       name;
    logic [39:0] frame;
    logic [39:0] exp_ht;
    int          exp_v;
    int          exp_c;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int c, v0, c0, t0, r0, ev, ec;
    logic [39:0] model_ht, f;
    logic [31:0] r;
    logic [7:0]  cs;

    vecs[0] = '{"neg_temp",  40'h028C806573, 40'h028C806573, 1, 0};
    vecs[1] = '{"good",      40'h028C015FEE, 40'h028C015FEE, 1, 0};
    vecs[2] = '{"bad_crc",   40'h028C015FEF, 40'h028C015FEE, 0, 1};

    rst_n = 1'b0; en = 1'b0; sensor_low = 1'b0;
    repeat (5) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    hold(1500);
    chk("en0_no_start", 40'(oe_rises), 40'd0);
    chk("en0_busy", {39'd0, busy}, 40'd0);

    en = 1'b1;
    wait_oe(1'b1, 1100, c);
    chk_rng("first_start_latency", c, 998, 1002);

    for (int i = 0; i < 3; i++) begin
      v0 = n_valid; c0 = n_crc; t0 = n_to;
      sensor_frame(vecs[i].frame, 40, 1'b0);
      wait_idle(600, c); chk_rng({vecs[i].name, "_idle"}, c, 0, 600);
      hold(3);
      chk({vecs[i].name, "_ht"}, HT_data, vecs[i].exp_ht);
      chk({vecs[i].name, "_sign"}, {39'd0, HT_data[23]}, {39'd0, vecs[i].exp_ht[23]});
      chk({vecs[i].name, "_valid"}, 40'(n_valid - v0), 40'(vecs[i].exp_v));
      chk({vecs[i].name, "_crc"}, 40'(n_crc - c0), 40'(vecs[i].exp_c));
      chk({vecs[i].name, "_to"}, 40'(n_to - t0), 40'd0);
      chk_rng({vecs[i].name, "_oe_width"}, last_oe_w, 1099, 1101);
    end
    model_ht = vecs[2].exp_ht;

    // silent sensor: timeout 200us after release, next start 1ms later
    t0 = n_to; v0 = n_valid;
    sensor_frame(40'd0, -1, 1'b0);
    wait_to(t0, 400, c);
    chk_rng("silent_timeout_latency", c, 198, 203);
    chk("silent_busy", {39'd0, busy}, 40'd0);
    chk("silent_valid", 40'(n_valid - v0), 40'd0);
    chk("silent_ht", HT_data, model_ht);
    wait_oe(1'b1, 1200, c);
    chk_rng("restart_after_timeout", c, 998, 1003);

    // sensor stops after bit 17
    t0 = n_to; v0 = n_valid; c0 = n_crc;
    sensor_frame(40'h5A3C_0F96_E1, 17, 1'b1);
    wait_to(t0, 400, c);
    chk_rng("partial_timeout_seen", c, 0, 400);
    hold(2);
    chk("partial_busy", {39'd0, busy}, 40'd0);
    chk("partial_valid", 40'(n_valid - v0), 40'd0);
    chk("partial_crc", 40'(n_crc - c0), 40'd0);
    chk("partial_ht", HT_data, model_ht);

    // random frames against the reference model
    for (int i = 0; i < 3; i++) begin
      r  = $urandom;
      cs = r[31:24] + r[23:16] + r[15:8] + r[7:0];
      if ($urandom_range(0, 2) == 0) cs = 8'($urandom);
      f = {r, cs};
      ref_frame(f, model_ht, ev, ec);
      v0 = n_valid; c0 = n_crc; t0 = n_to;
      sensor_frame(f, 40, 1'b1);
      wait_idle(600, c); chk_rng("rand_idle", c, 0, 600);
      hold(3);
      chk("rand_ht", HT_data, model_ht);
      chk("rand_valid", 40'(n_valid - v0), 40'(ev));
      chk("rand_crc", 40'(n_crc - c0), 40'(ec));
      chk("rand_to", 40'(n_to - t0), 40'd0);
      chk_rng("rand_oe_width", last_oe_w, 1099, 1101);
    end

    // reset while the DUT is in a bit high phase
    sensor_frame(40'hFFFF_FFFF_FF, 5, 1'b0);
    hold(20);
    chk("bit_high_busy", {39'd0, busy}, 40'd1);
    rst_n = 1'b0; #1;
    chk_zero("reset_bit_high");
    hold(5);
    rst_n = 1'b1;

    // reset during the start pulse, then en=0 must never start again
    wait_oe(1'b1, 1200, c);
    chk_rng("start_after_reset", c, 995, 1005);
    hold(100);
    rst_n = 1'b0; #1;
    chk_zero("reset_start");
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r0 = oe_rises;
    hold(2500);
    chk("en0_after_reset_starts", 40'(oe_rises - r0), 40'd0);
    chk("en0_after_reset_busy", {39'd0, busy}, 40'd0);

    chk("bus_contention", 40'(n_contend), 40'd0);
    chk("pulse_width_one_cycle", 40'(n_long), 40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
